// File: rtl/cache_pkg.sv
// Shared cache-side types: memory request struct, access sizes and the
// store-buffer entry, plus helpers for byte masks and load extension.
package cache_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic            enable;
    logic [AW-1:0]   address;
    logic [XLEN-1:0] data;
    mem_size_t       size;
    logic            use_unsigned;
  } mem_data_t;

  // One buffered store; mask marks the bytes it writes within its word.
  typedef struct packed {
    mem_data_t  mem;
    logic [3:0] mask;
  } sb_entry_t;

  function automatic logic [3:0] size_to_mask(mem_size_t size, logic [1:0] offset);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << offset;
      SIZE_HALF: m = 4'b0011 << offset;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store data is lane-aligned, so the load's bytes sit at offset*8.
  function automatic logic [XLEN-1:0] extend_load(logic [XLEN-1:0] word, logic [1:0] offset,
                                                  mem_size_t size, logic use_unsigned);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    sh = word >> {offset, 3'b000};
    case (size)
      SIZE_BYTE: r = use_unsigned ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SIZE_HALF: r = use_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:   r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// Youngest-match priority select over the buffered stores plus the
// coverage check that decides forward / stall for the current load.
// STORE_BUFFER_FWD_EN enables the forward mux; without it any word match
// only stalls the load.
module sb_fwd_select
  import cache_pkg::*;
#(
  parameter int N_ENTRIES  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  sb_entry_t [N_ENTRIES-1:0]         entries_i,
  input  logic [N_ENTRIES-1:0]              valid_i,
  input  logic [$clog2(N_ENTRIES)-1:0]      head_i,
  input  mem_data_t                         load_i,
  output logic                              hit_o,
  output logic                              stall_o,
  output logic [XLEN-1:0]                   data_o
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] idx;
  logic             unused_ok;

  // Walk oldest to youngest from head; the last match seen is the youngest.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_ENTRIES; k++) begin
      idx = head_i + IDX_W'(k);
      if (valid_i[idx] &&
          entries_i[idx].mem.address[ADDR_WIDTH-1:2] == load_i.address[ADDR_WIDTH-1:2]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [3:0] lmask;
  logic [3:0] ovl;

  // Full coverage forwards, partial overlap stalls, disjoint bytes do neither.
  always_comb begin
    lmask   = size_to_mask(load_i.size, load_i.address[1:0]);
    ovl     = entries_i[win].mask & lmask;
    hit_o   = load_i.enable && found && (ovl == lmask);
    stall_o = load_i.enable && found && (|ovl) && (ovl != lmask);
    data_o  = '0;
    if (hit_o)
      data_o = extend_load(entries_i[win].mem.data, load_i.address[1:0],
                           load_i.size, load_i.use_unsigned);
  end
`else
  // Forwarding disabled: any buffered store to the same word holds the load.
  always_comb begin
    hit_o   = 1'b0;
    stall_o = load_i.enable && found;
    data_o  = '0;
  end
`endif

  assign unused_ok = ^{entries_i, load_i, win};

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO between the memory stage and the dcache. Drains
// oldest-first when no load owns the cache and forwards to younger loads.
// Optional macro: STORE_BUFFER_FWD_EN (store-to-load data forwarding).
// Valid/ready: a transfer happens on a cycle where the producer's enable
// and the consumer's ready are both high at the clock edge; enable never
// depends on ready.
module store_buffer
  import cache_pkg::*;
#(
  parameter int N_ENTRIES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  mem_data_t                    i_st,
  output logic                         o_st_ready,
  input  mem_data_t                    i_load,
  output logic                         o_fwd_hit,
  output logic [REG_WIDTH-1:0]         o_fwd_data,
  output logic                         o_fwd_stall,
  output mem_data_t                    o_drain,
  input  logic                         i_drain_ready,
  output logic                         o_empty,
  output logic [$clog2(N_ENTRIES):0]   o_count
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  sb_entry_t [N_ENTRIES-1:0] entries_q;
  logic [N_ENTRIES-1:0]      valid_q;
  logic [IDX_W:0]            head_q, head_d;
  logic [IDX_W:0]            tail_q, tail_d;
  logic                      full;
  logic                      push;
  logic                      pop;
  logic [XLEN-1:0]           fwd_data;

  assign full       = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign o_empty    = (head_q == tail_q);
  assign o_count    = tail_q - head_q;
  assign o_st_ready = !full;
  assign push       = i_st.enable && o_st_ready;
  assign pop        = o_drain.enable && i_drain_ready;

  // Present the head entry to the dcache; a pending load owns the cache.
  always_comb begin
    o_drain        = entries_q[head_q[IDX_W-1:0]].mem;
    o_drain.enable = !o_empty && !i_load.enable;
  end

  // Pointer advance; the extra top bit flips on every wrap.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
  end

  // Entry storage, valid bits and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      if (pop)
        valid_q[head_q[IDX_W-1:0]] <= 1'b0;
      if (push) begin
        entries_q[tail_q[IDX_W-1:0]].mem  <= i_st;
        entries_q[tail_q[IDX_W-1:0]].mask <= size_to_mask(i_st.size, i_st.address[1:0]);
        valid_q[tail_q[IDX_W-1:0]]        <= 1'b1;
      end
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  sb_fwd_select #(
    .N_ENTRIES (N_ENTRIES),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fwd (
    .entries_i(entries_q),
    .valid_i  (valid_q),
    .head_i   (head_q[IDX_W-1:0]),
    .load_i   (i_load),
    .hit_o    (o_fwd_hit),
    .stall_o  (o_fwd_stall),
    .data_o   (fwd_data)
  );

  assign o_fwd_data = REG_WIDTH'(fwd_data);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, FIFO/full behaviour, forwarding
// table and multi-cycle corner sequences, with an expected drain queue.
module tb_store_buffer;
  import cache_pkg::*;

  logic        clk;
  logic        rst;
  mem_data_t   i_st;
  logic        o_st_ready;
  mem_data_t   i_load;
  logic        o_fwd_hit;
  logic [31:0] o_fwd_data;
  logic        o_fwd_stall;
  mem_data_t   o_drain;
  logic        i_drain_ready;
  logic        o_empty;
  logic [2:0]  o_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  store_buffer #(.N_ENTRIES(4), .ADDR_WIDTH(32), .REG_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_st(i_st), .o_st_ready(o_st_ready), .i_load(i_load),
    .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data), .o_fwd_stall(o_fwd_stall),
    .o_drain(o_drain), .i_drain_ready(i_drain_ready), .o_empty(o_empty), .o_count(o_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  function automatic mem_data_t req(logic en, logic [31:0] a, logic [31:0] d,
                                    mem_size_t s, logic u);
    mem_data_t r;
    r.enable = en; r.address = a; r.data = d; r.size = s; r.use_unsigned = u;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input mem_size_t s);
    i_st = req(1'b1, a, d, s, 1'b0);
    step();
    i_st.enable = 1'b0;
  endtask

  // Scoreboard: drain everything, checking FIFO order against exp_q.
  task automatic drain_all(input string tag);
    int n;
    n = exp_q.size();
    i_drain_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_drain_en"}, 32'(o_drain.enable), 32'd1);
      check({tag, "_drain_data"}, o_drain.data, exp_q.pop_front());
      step();
    end
    i_drain_ready = 1'b0;
    check({tag, "_empty_after"}, 32'(o_empty), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        en;
    logic [31:0] addr;
    mem_size_t   size;
    logic        uns;
    logic        hit;    // expected with forwarding
    logic        stall;  // expected with forwarding
    logic [31:0] data;   // expected with forwarding
    logic        match;  // load word matches a buffered store
  } fwd_vec_t;

  fwd_vec_t vecs[12];

  initial begin
    logic eh, es;
    logic [31:0] ed;

    vecs[0]  = '{"byte_s_200",   1, 32'h200, SIZE_BYTE, 0, 1, 0, 32'hFFFFFF80, 1};
    vecs[1]  = '{"byte_u_200",   1, 32'h200, SIZE_BYTE, 1, 1, 0, 32'h00000080, 1};
    vecs[2]  = '{"half_s_202",   1, 32'h202, SIZE_HALF, 0, 1, 0, 32'hFFFF8000, 1};
    vecs[3]  = '{"half_u_202",   1, 32'h202, SIZE_HALF, 1, 1, 0, 32'h00008000, 1};
    vecs[4]  = '{"byte_s_201",   1, 32'h201, SIZE_BYTE, 0, 1, 0, 32'hFFFFFFFF, 1};
    vecs[5]  = '{"word_300",     1, 32'h300, SIZE_WORD, 0, 0, 1, 32'h0,        1};
    vecs[6]  = '{"byte_u_300",   1, 32'h300, SIZE_BYTE, 1, 1, 0, 32'h00000012, 1};
    vecs[7]  = '{"byte_301",     1, 32'h301, SIZE_BYTE, 0, 0, 0, 32'h0,        1};
    vecs[8]  = '{"word_400",     1, 32'h400, SIZE_WORD, 0, 1, 0, 32'h22222222, 1};
    vecs[9]  = '{"half_u_402",   1, 32'h402, SIZE_HALF, 1, 1, 0, 32'h00002222, 1};
    vecs[10] = '{"word_500",     1, 32'h500, SIZE_WORD, 0, 0, 0, 32'h0,        0};
    vecs[11] = '{"disabled_200", 0, 32'h200, SIZE_WORD, 0, 0, 0, 32'h0,        0};

    // Reset
    rst = 1'b1;
    i_st = '0;
    i_load = '0;
    i_drain_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_st_ready", 32'(o_st_ready), 32'd1);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_drain_en", 32'(o_drain.enable), 32'd0);
    check("rst_fwd_hit", 32'(o_fwd_hit), 32'd0);
    check("rst_fwd_stall", 32'(o_fwd_stall), 32'd0);
    check("rst_fwd_data", o_fwd_data, 32'd0);

    // Single store, held, then drained
    push(32'h100, 32'hDEADBEEF, SIZE_WORD);
    check("one_count", 32'(o_count), 32'd1);
    check("one_drain_en", 32'(o_drain.enable), 32'd1);
    check("one_drain_addr", o_drain.address, 32'h100);
    check("one_drain_data", o_drain.data, 32'hDEADBEEF);
    i_drain_ready = 1'b1;
    step();
    i_drain_ready = 1'b0;
    check("one_empty", 32'(o_empty), 32'd1);

    // Fill, refused push at full with concurrent pop, wrap, FIFO order
    for (int i = 0; i < 4; i++) begin
      push(32'h10 + 32'(i * 4), 32'hA0 + 32'(i), SIZE_WORD);
      exp_q.push_back(32'hA0 + 32'(i));
    end
    check("full_st_ready", 32'(o_st_ready), 32'd0);
    check("full_count", 32'(o_count), 32'd4);
    i_st = req(1'b1, 32'h20, 32'hA4, SIZE_WORD, 1'b0);
    i_drain_ready = 1'b1;
    #1;
    check("full_pop_ready", 32'(o_st_ready), 32'd0);
    check("full_pop_head", o_drain.data, exp_q.pop_front());
    step();
    i_drain_ready = 1'b0;
    check("refused_count", 32'(o_count), 32'd3);
    check("refused_ready", 32'(o_st_ready), 32'd1);
    step();  // i_st still held: now accepted
    i_st.enable = 1'b0;
    exp_q.push_back(32'hA4);
    check("wrap_count", 32'(o_count), 32'd4);
    drain_all("wrap");

    // Forwarding table over a full buffer
    push(32'h200, 32'h8000FF80, SIZE_WORD); exp_q.push_back(32'h8000FF80);
    push(32'h300, 32'h00000012, SIZE_BYTE); exp_q.push_back(32'h00000012);
    push(32'h400, 32'h11111111, SIZE_WORD); exp_q.push_back(32'h11111111);
    push(32'h400, 32'h22222222, SIZE_WORD); exp_q.push_back(32'h22222222);
    for (int i = 0; i < 12; i++) begin
`ifdef STORE_BUFFER_FWD_EN
      eh = vecs[i].hit; es = vecs[i].stall; ed = vecs[i].data;
`else
      eh = 1'b0; es = vecs[i].match; ed = 32'h0;
`endif
      i_load = req(vecs[i].en, vecs[i].addr, 32'h0, vecs[i].size, vecs[i].uns);
      #1;
      check({vecs[i].name, "_hit"}, 32'(o_fwd_hit), 32'(eh));
      check({vecs[i].name, "_stall"}, 32'(o_fwd_stall), 32'(es));
      check({vecs[i].name, "_data"}, o_fwd_data, ed);
      check({vecs[i].name, "_drain_en"}, 32'(o_drain.enable), 32'(!vecs[i].en));
    end
    i_load = '0;
    #1;
    drain_all("fwd");
    i_load = req(1'b1, 32'h300, 32'h0, SIZE_WORD, 1'b0);
    #1;
    check("drained_stall", 32'(o_fwd_stall), 32'd0);
    check("drained_hit", 32'(o_fwd_hit), 32'd0);

    // Store pushed this cycle is not yet visible to a load
    i_st = req(1'b1, 32'h600, 32'h5, SIZE_WORD, 1'b0);
    i_load = req(1'b1, 32'h600, 32'h0, SIZE_WORD, 1'b0);
    #1;
    check("same_cyc_hit", 32'(o_fwd_hit), 32'd0);
    check("same_cyc_stall", 32'(o_fwd_stall), 32'd0);
    step();
    i_st.enable = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    eh = 1'b1; es = 1'b0; ed = 32'h5;
`else
    eh = 1'b0; es = 1'b1; ed = 32'h0;
`endif
    check("next_cyc_hit", 32'(o_fwd_hit), 32'(eh));
    check("next_cyc_stall", 32'(o_fwd_stall), 32'(es));
    check("next_cyc_data", o_fwd_data, ed);
    check("next_cyc_drain_en", 32'(o_drain.enable), 32'd0);
    i_load = '0;
    exp_q.push_back(32'h5);
    #1;
    drain_all("late");

    // Asynchronous reset in the middle of draining
    push(32'h700, 32'h1, SIZE_WORD);
    push(32'h704, 32'h2, SIZE_WORD);
    push(32'h708, 32'h3, SIZE_WORD);
    i_drain_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("arst_empty", 32'(o_empty), 32'd1);
    check("arst_count", 32'(o_count), 32'd0);
    check("arst_drain_en", 32'(o_drain.enable), 32'd0);
    check("arst_st_ready", 32'(o_st_ready), 32'd1);
    #1 rst = 1'b0;
    step();
    check("post_rst_drain_en", 32'(o_drain.enable), 32'd0);
    check("post_rst_empty", 32'(o_empty), 32'd1);
    i_drain_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
